// File: rtl/jtframe_sdram_sched.sv
// Request scheduler between the four game bank ports, the ROM-download port
// and a single-command SDRAM core: round-robin access grants plus auto-refresh.
module jtframe_sdram_sched #(
    parameter int AW          = 22,
    parameter int RFSH_PERIOD = 384,
    parameter int RFSH_MAX    = 8
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            prog_en,
    input  logic            prog_rd,
    input  logic            prog_we,
    input  logic [1:0]      prog_ba,
    input  logic [AW-1:0]   prog_addr,
    output logic            prog_ack,
    output logic            prog_rdy,
    input  logic [3:0]      ba_rd,
    input  logic            ba0_wr,
    input  logic [4*AW-1:0] ba_addr,
    output logic [3:0]      ba_ack,
    output logic [3:0]      ba_rdy,
    input  logic            rfsh_en,
    input  logic            core_cmd_ok,
    input  logic            core_dok,
    input  logic [1:0]      core_dba,
    output logic            core_issue,
    output logic            core_rfsh,
    output logic [1:0]      core_ba,
    output logic [AW-1:0]   core_addr,
    output logic            core_wr
);
    localparam int CW = $clog2(RFSH_PERIOD + 1);
    localparam int PW = $clog2(RFSH_MAX + 1);
    localparam logic [CW-1:0] PERIOD_V = CW'(RFSH_PERIOD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] MAX_V    = PW'(RFSH_MAX);
    localparam logic [PW-1:0] PEND_ONE = PW'(1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_RFSH} state_t;

    state_t          state_q;
    logic [3:0]      busy_q;
    logic            prog_busy_q;
    logic [1:0]      rr_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   pend_q;
    logic            force_q;

    logic            prog_ack_q, prog_rdy_q, core_issue_q, core_rfsh_q, core_wr_q;
    logic [3:0]      ba_ack_q, ba_rdy_q;
    logic [1:0]      core_ba_q;
    logic [AW-1:0]   core_addr_q;

    logic [3:0]      req_w, elig_w;
    logic [AW-1:0]   addr_w [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        assign req_w[gi]  = ba_rd[gi] | ((gi == 0) ? ba0_wr : 1'b0);
        assign elig_w[gi] = req_w[gi] & ~busy_q[gi] & ~ba_ack_q[gi];
        assign addr_w[gi] = ba_addr[gi*AW +: AW];
    end

    logic            gnt_found;
    logic [1:0]      gnt_idx, cand;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        cand      = rr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!gnt_found && elig_w[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    logic            bank_gnt, prog_gnt;
    logic            rfsh_tick, rfsh_inc, rfsh_dec;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   pend_d;

    assign bank_gnt  = (state_q == ST_RUN) && !prog_en && core_cmd_ok && gnt_found;
    assign prog_gnt  = (state_q == ST_RUN) && prog_en && core_cmd_ok &&
                       (prog_rd || prog_we) && !prog_busy_q && !prog_ack_q;

    // The counter expires on the cycle it would reach zero, so requests are RFSH_PERIOD apart.
    assign rfsh_tick = (cnt_q == CNT_ONE);
    assign cnt_d     = rfsh_tick ? PERIOD_V : cnt_q - CNT_ONE;
    assign rfsh_inc  = rfsh_tick && (pend_q != MAX_V);
    assign rfsh_dec  = (state_q == ST_RFSH) && core_cmd_ok && (pend_q != '0);
    assign pend_d    = pend_q + (rfsh_inc ? PEND_ONE : '0) - (rfsh_dec ? PEND_ONE : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            busy_q       <= '0;
            prog_busy_q  <= 1'b0;
            rr_q         <= '0;
            cnt_q        <= PERIOD_V;
            pend_q       <= '0;
            force_q      <= 1'b0;
            prog_ack_q   <= 1'b0;
            prog_rdy_q   <= 1'b0;
            ba_ack_q     <= '0;
            ba_rdy_q     <= '0;
            core_issue_q <= 1'b0;
            core_rfsh_q  <= 1'b0;
            core_ba_q    <= '0;
            core_addr_q  <= '0;
            core_wr_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            prog_ack_q   <= 1'b0;
            prog_rdy_q   <= 1'b0;
            ba_ack_q     <= '0;
            ba_rdy_q     <= '0;
            core_issue_q <= 1'b0;
            core_rfsh_q  <= 1'b0;

            // Bank completions take priority; otherwise a completion belongs to the prog access.
            if (core_dok) begin
                if (busy_q[core_dba]) begin
                    busy_q[core_dba]   <= 1'b0;
                    ba_rdy_q[core_dba] <= 1'b1;
                end else if (prog_busy_q) begin
                    prog_busy_q <= 1'b0;
                    prog_rdy_q  <= 1'b1;
                end
            end

            case (state_q)
                ST_RUN: begin
                    if (bank_gnt) begin
                        busy_q[gnt_idx]   <= 1'b1;
                        ba_ack_q[gnt_idx] <= 1'b1;
                        core_issue_q      <= 1'b1;
                        core_ba_q         <= gnt_idx;
                        core_addr_q       <= addr_w[gnt_idx];
                        core_wr_q         <= (gnt_idx == 2'd0) && ba0_wr;
                        rr_q              <= gnt_idx + 2'd1;
                    end else if (prog_gnt) begin
                        prog_busy_q  <= 1'b1;
                        prog_ack_q   <= 1'b1;
                        core_issue_q <= 1'b1;
                        core_ba_q    <= prog_ba;
                        core_addr_q  <= prog_addr;
                        core_wr_q    <= prog_we;
                    end else if (pend_q != '0 && (rfsh_en || pend_q == MAX_V)) begin
                        state_q <= ST_DRAIN;
                        force_q <= (pend_q == MAX_V);
                    end
                end
                ST_DRAIN: begin
                    if (busy_q == 4'd0 && !prog_busy_q)
                        state_q <= ST_RFSH;
                end
                ST_RFSH: begin
                    if (core_cmd_ok) begin
                        core_rfsh_q <= 1'b1;
                        // A forced burst keeps going until the backlog is empty.
                        if (pend_d == '0 || !(rfsh_en || force_q)) begin
                            state_q <= ST_RUN;
                            force_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign prog_ack   = prog_ack_q;
    assign prog_rdy   = prog_rdy_q;
    assign ba_ack     = ba_ack_q;
    assign ba_rdy     = ba_rdy_q;
    assign core_issue = core_issue_q;
    assign core_rfsh  = core_rfsh_q;
    assign core_ba    = core_ba_q;
    assign core_addr  = core_addr_q;
    assign core_wr    = core_wr_q;

endmodule
